// File: rtl/idct2_pkg.sv
// Shared constants and helpers for the IDCT2 multiply pipeline.
package idct2_pkg;

  localparam int unsigned MAX_W      = 128;
  localparam int unsigned DOUT_W_DEF = 16;

  function automatic logic signed [MAX_W-1:0] round_const(input int unsigned shift);
    return (shift == 0) ? '0 : (MAX_W'(1) << (shift - 1));
  endfunction

  function automatic logic signed [MAX_W-1:0] sat_max(input int unsigned w);
    return (MAX_W'(1) << (w - 1)) - MAX_W'(1);
  endfunction

  function automatic logic signed [MAX_W-1:0] sat_min(input int unsigned w);
    return -(MAX_W'(1) << (w - 1));
  endfunction

  localparam logic signed [MAX_W-1:0] DOUT_MAX = sat_max(DOUT_W_DEF);
  localparam logic signed [MAX_W-1:0] DOUT_MIN = sat_min(DOUT_W_DEF);

endpackage

// File: rtl/idct2_round_sat.sv
// Combinational round-half-up, arithmetic shift and optional signed saturation.
module idct2_round_sat
  import idct2_pkg::*;
#(
  parameter int unsigned P      = 40,
  parameter int unsigned SHIFT  = 7,
  parameter int unsigned SAT    = 1,
  parameter int unsigned DOUT_W = 16
) (
  input  logic signed [P-1:0]      prod,
  output logic signed [DOUT_W-1:0] dout,
  output logic                     flag
);

  // One guard bit keeps the rounding add exact for every legal SHIFT.
  localparam logic signed [P:0] RND = (P+1)'(round_const(SHIFT));
  localparam logic signed [P:0] HI  = (P+1)'(sat_max(DOUT_W));
  localparam logic signed [P:0] LO  = (P+1)'(sat_min(DOUT_W));

  logic signed [P:0] sum;
  logic signed [P:0] r;
  logic              over;
  logic              under;

  always_comb begin
    sum   = {prod[P-1], prod} + RND;
    r     = sum >>> SHIFT;
    over  = (r > HI);
    under = (r < LO);
    dout  = r[DOUT_W-1:0];
    flag  = 1'b0;
    if (SAT != 0) begin
      if (over) begin
        dout = HI[DOUT_W-1:0];
        flag = 1'b1;
      end else if (under) begin
        dout = LO[DOUT_W-1:0];
        flag = 1'b1;
      end
    end
  end

endmodule

// File: rtl/idct2_mul_pipe.sv
// Pipelined signed coefficient x sample multiplier with valid/ready flow control,
// rounding shift and saturation; bubbles collapse, capacity is NUM_STAGE beats.
module idct2_mul_pipe
  import idct2_pkg::*;
#(
  parameter int unsigned DIN0_W    = 32,
  parameter int unsigned DIN1_W    = 8,
  parameter int unsigned DOUT_W    = 16,
  parameter int unsigned NUM_STAGE = 3,
  parameter int unsigned SHIFT     = 7,
  parameter int unsigned SAT       = 1
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DIN0_W-1:0]        din0,
  input  logic [DIN1_W-1:0]        din1,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DOUT_W-1:0] dout,
  output logic                     sat_flag
);

  localparam int unsigned P = DIN0_W + DIN1_W;

  logic [P-1:0]      prod;
  logic [DOUT_W-1:0] res;
  logic              res_flag;

  logic [NUM_STAGE-1:0]             vld;
  logic [NUM_STAGE-1:0]             flg;
  logic [NUM_STAGE-1:0]             ld;
  logic [NUM_STAGE-1:0][DOUT_W-1:0] dat;

  // Sign-extend both operands to P bits; the low P bits of the product are exact.
  assign prod = {{DIN1_W{din0[DIN0_W-1]}}, din0} * {{DIN0_W{din1[DIN1_W-1]}}, din1};

  idct2_round_sat #(
    .P      (P),
    .SHIFT  (SHIFT),
    .SAT    (SAT),
    .DOUT_W (DOUT_W)
  ) u_round_sat (
    .prod (prod),
    .dout (res),
    .flag (res_flag)
  );

  // A slot may load when empty or when its contents move on this cycle.
  always_comb begin
    ld = '0;
    ld[NUM_STAGE-1] = !vld[NUM_STAGE-1] || out_ready;
    for (int unsigned i = 1; i < NUM_STAGE; i++) begin
      ld[NUM_STAGE-1-i] = !vld[NUM_STAGE-1-i] || ld[NUM_STAGE-i];
    end
  end

  for (genvar k = 0; k < NUM_STAGE; k++) begin : g_slot
    logic              v;
    logic              f;
    logic [DOUT_W-1:0] d;
    logic              sv;
    logic              sf;
    logic [DOUT_W-1:0] sd;

    if (k == 0) begin : g_head
      assign sv = in_valid;
      assign sd = res;
      assign sf = res_flag;
    end else begin : g_body
      assign sv = vld[k-1];
      assign sd = dat[k-1];
      assign sf = flg[k-1];
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
        v <= 1'b0;
        d <= '0;
        f <= 1'b0;
      end else if (ld[k]) begin
        v <= sv;
        if (sv) begin
          d <= sd;
          f <= sf;
        end
      end
    end

    assign vld[k] = v;
    assign dat[k] = d;
    assign flg[k] = f;
  end

  assign in_ready  = ld[0];
  assign out_valid = vld[NUM_STAGE-1];
  assign dout      = dat[NUM_STAGE-1];
  assign sat_flag  = flg[NUM_STAGE-1];

endmodule

// File: tb/tb_idct2_mul_pipe.sv
// Self-checking bench for idct2_mul_pipe: directed vectors, stall/reset sequences,
// and a random valid/ready stream scored against an arithmetic reference model.
module tb_idct2_mul_pipe;

  localparam int NBEAT = 10000;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               out_ready = 1'b0;
  logic signed [31:0] din0 = '0;
  logic signed [7:0]  din1 = '0;

  logic               in_ready, out_valid, sat_flag;
  logic signed [15:0] dout;
  logic               in_ready_w, out_valid_w, sat_flag_w;
  logic signed [15:0] dout_w;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int a;
    int b;
    int d;
    bit f;
    int dw;
  } vec_t;

  typedef struct {
    int d;
    bit f;
    int dw;
  } exp_t;

  vec_t vecs[9];
  exp_t sb[$];
  exp_t mon_e;
  bit   mon_en = 1'b0;
  int   n_out  = 0;

  idct2_mul_pipe dut (
    .ap_clk    (clk),
    .ap_rst    (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din0      (din0),
    .din1      (din1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .sat_flag  (sat_flag)
  );

  idct2_mul_pipe #(.SAT(0)) dut_wrap (
    .ap_clk    (clk),
    .ap_rst    (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready_w),
    .din0      (din0),
    .din1      (din1),
    .out_valid (out_valid_w),
    .out_ready (out_ready),
    .dout      (dout_w),
    .sat_flag  (sat_flag_w)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: exact product, floor((p + 64) / 128), then clamp or wrap to 16 bits.
  function automatic exp_t model(input logic signed [31:0] a, input logic signed [7:0] b);
    exp_t   e;
    longint p, n, q, m;
    p = longint'(a) * longint'(b);
    n = p + 64;
    q = n / 128;
    if ((n % 128 != 0) && (n < 0)) q = q - 1;
    if (q > 32767) begin
      e.d = 32767;  e.f = 1'b1;
    end else if (q < -32768) begin
      e.d = -32768; e.f = 1'b1;
    end else begin
      e.d = int'(q); e.f = 1'b0;
    end
    m = q & 64'hFFFF;
    e.dw = (m >= 32768) ? int'(m - 65536) : int'(m);
    return e;
  endfunction

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (in_valid && in_ready) sb.push_back(model(din0, din1));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          check("rand_dout", dout, mon_e.d);
          check("rand_flag", sat_flag, mon_e.f);
          check("rand_wrap_dout", dout_w, mon_e.dw);
          check("rand_wrap_flag", sat_flag_w, 0);
        end
        n_out++;
      end
    end
  end

  initial begin
    int  lat, nacc, nout, c, stalls, gaps, sent, cyc, n_out0;
    bit  fired;

    vecs[0] = '{1000, 90, 703, 1'b0, 703};
    vecs[1] = '{1000, -64, -500, 1'b0, -500};
    vecs[2] = '{-1, 1, 0, 1'b0, 0};
    vecs[3] = '{100000, 64, 32767, 1'b1, -15536};
    vecs[4] = '{-100000, 64, -32768, 1'b1, 15536};
    vecs[5] = '{65534, 64, 32767, 1'b0, 32767};
    vecs[6] = '{65535, 64, 32767, 1'b1, -32768};
    vecs[7] = '{-65536, 64, -32768, 1'b0, -32768};
    vecs[8] = '{-2147483647 - 1, -128, 32767, 1'b1, 0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_dout", dout, 0);
    check("rst_sat_flag", sat_flag, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);

    // Directed vectors, one isolated beat each
    out_ready = 1'b1;
    foreach (vecs[i]) begin
      @(posedge clk); #1;
      din0 = vecs[i].a;
      din1 = 8'(vecs[i].b);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
        @(posedge clk); #1;
        lat++;
      end
      check("vec_latency", lat, 2);
      check("vec_dout", dout, vecs[i].d);
      check("vec_flag", sat_flag, vecs[i].f);
      check("vec_wrap_dout", dout_w, vecs[i].dw);
      check("vec_wrap_flag", sat_flag_w, 0);
    end
    @(posedge clk); #1;

    // Back-pressure: fill with out_ready low, then release
    out_ready = 1'b0;
    in_valid  = 1'b1;
    din0 = 1;
    din1 = -8'sd128;
    nacc = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      fired = in_valid && in_ready;
      if (nacc >= 3) begin
        check("stall_in_ready", in_ready, 0);
        check("stall_out_valid", out_valid, 1);
        check("stall_hold_dout", dout, -1);
      end
      @(posedge clk); #1;
      if (fired) begin
        nacc++;
        din0 = nacc + 1;
      end
    end
    check("stall_accepts", nacc, 3);
    out_ready = 1'b1;
    #1;
    check("full_release_in_ready", in_ready, 1);
    nout = 0;
    c = 0;
    while (nout < 10 && c < 40) begin
      @(negedge clk);
      fired = in_valid && in_ready;
      if (out_valid && out_ready) begin
        check("stall_order", dout, -(nout + 1));
        nout++;
      end
      @(posedge clk); #1;
      c++;
      if (fired) begin
        nacc++;
        if (nacc == 10) in_valid = 1'b0;
        else din0 = nacc + 1;
      end
    end
    check("stall_out_count", nout, 10);
    @(negedge clk);
    check("stall_no_dup", out_valid, 0);

    // Full throughput with both sides held high
    @(posedge clk); #1;
    mon_en = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    stalls = 0;
    gaps = 0;
    for (int k = 0; k < 40; k++) begin
      din0 = $urandom;
      din1 = 8'($urandom);
      @(negedge clk);
      if (!in_ready) stalls++;
      if (k >= 3 && !out_valid) gaps++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("thru_in_stalls", stalls, 0);
    check("thru_out_gaps", gaps, 0);

    // Random valid/ready stream against the reference model
    n_out0 = n_out;
    sent = 0;
    cyc = 0;
    while ((sent < NBEAT || sb.size() != 0) && cyc < 60000) begin
      @(negedge clk);
      fired = in_valid && in_ready;
      @(posedge clk); #1;
      cyc++;
      if (fired) sent++;
      if (!in_valid || fired) begin
        in_valid = (sent < NBEAT) && ($urandom_range(0, 1) == 1);
        din0 = $urandom;
        din1 = 8'($urandom);
      end
      out_ready = ($urandom_range(0, 1) == 1);
    end
    in_valid = 1'b0;
    check("rand_no_timeout", (cyc < 60000) ? 1 : 0, 1);
    check("rand_beats_out", n_out - n_out0, NBEAT);
    check("rand_sb_empty", sb.size(), 0);
    mon_en = 1'b0;

    // Asynchronous reset with three beats in flight
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      din0 = 5 + k;
      din1 = -8'sd128;
      in_valid = 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("pre_rst_out_valid", out_valid, 1);
    check("pre_rst_dout", dout, -5);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_dout", dout, 0);
    check("async_rst_flag", sat_flag, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    din0 = 11;
    din1 = -8'sd128;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("post_rst_latency", lat, 2);
    check("post_rst_first_dout", dout, -11);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
